// File: rtl/id_serialize_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_serialize_ctl_if
//  Brief    : ID-to-EXE handshake bundle for the serialization controller.
//             master = decode/forwarding side driving the request,
//             slave  = the serialization controller itself.
//  Revision : 1.0  initial release
// ============================================================================
interface id_serialize_ctl_if #(
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 8
);
    // Requests from ID and hazard logic
    logic                 Valid_IN;
    logic                 Serialize_IN;
    logic                 Notify_IN;
    logic [PAYLOAD_W-1:0] Payload_IN;
    logic                 Fwd_Freeze_IN;
    logic                 Flush_IN;

    // Results toward EXE, fetch and the simulator hook
    logic [PAYLOAD_W-1:0] Payload_OUT;
    logic                 Valid_OUT;
    logic                 Serialize_OUT;
    logic                 WANT_FREEZE;
    logic                 SYS;
    logic                 Busy;
    logic [CNT_W-1:0]     Serialize_Count_OUT;

    modport master (
        output Valid_IN,
        output Serialize_IN,
        output Notify_IN,
        output Payload_IN,
        output Fwd_Freeze_IN,
        output Flush_IN,
        input  Payload_OUT,
        input  Valid_OUT,
        input  Serialize_OUT,
        input  WANT_FREEZE,
        input  SYS,
        input  Busy,
        input  Serialize_Count_OUT
    );

    modport slave (
        input  Valid_IN,
        input  Serialize_IN,
        input  Notify_IN,
        input  Payload_IN,
        input  Fwd_Freeze_IN,
        input  Flush_IN,
        output Payload_OUT,
        output Valid_OUT,
        output Serialize_OUT,
        output WANT_FREEZE,
        output SYS,
        output Busy,
        output Serialize_Count_OUT
    );
endinterface
`default_nettype wire

// File: rtl/id_serialize_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : id_serialize_ctl
//  Brief    : ID/EXE pipeline register with serializing-instruction control.
//             A serializing instruction (syscall, LL/SC) issues once, then
//             the stage emits DRAIN_CYCLES bubbles, a NOTIFY bubble and a
//             RELEASE bubble (carrying the optional SYS pulse) before normal
//             issue resumes. Fetch is frozen from the issue cycle through
//             NOTIFY and released in RELEASE so it steps past the instruction.
//  Revision : 1.0  initial release
// ============================================================================
module id_serialize_ctl #(
    parameter int PAYLOAD_W    = 128,
    parameter int DRAIN_CYCLES = 3,     // legal range 1..15
    parameter int CNT_W        = 8
) (
    input  wire logic         CLK,
    input  wire logic         RESET,    // asynchronous, active low
    id_serialize_ctl_if.slave bus
);

    // Drain counter is sized for the full legal DRAIN_CYCLES range.
    localparam int         DCNT_W     = 4;
    localparam [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        NOTIFY  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t               state;
    logic [DCNT_W-1:0]    drain_cnt;
    logic                 notify_latched;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 valid_q;
    logic                 serialize_q;
    logic                 sys_q;
    logic [CNT_W-1:0]     ser_count_q;
    logic                 want_freeze;

    // Sequencer plus all registered outputs; every non-issuing cycle is a bubble.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            notify_latched <= 1'b0;
            payload_q      <= '0;
            valid_q        <= 1'b0;
            serialize_q    <= 1'b0;
            sys_q          <= 1'b0;
            ser_count_q    <= '0;
        end else begin
            // Bubble and no notification unless a branch below says otherwise.
            payload_q   <= '0;
            valid_q     <= 1'b0;
            serialize_q <= 1'b0;
            sys_q       <= 1'b0;

            case (state)
                IDLE: begin
                    // Flush beats freeze beats issue; flush/freeze yield a bubble.
                    if (!bus.Flush_IN && !bus.Fwd_Freeze_IN && bus.Valid_IN) begin
                        payload_q <= bus.Payload_IN;
                        valid_q   <= 1'b1;
                        if (bus.Serialize_IN) begin
                            serialize_q    <= 1'b1;
                            notify_latched <= bus.Notify_IN;
                            drain_cnt      <= DRAIN_INIT;
                            state          <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // Let the serializing instruction clear MEM/WB before notifying.
                    drain_cnt <= drain_cnt - DCNT_W'(1);
                    if (drain_cnt == DCNT_W'(1)) begin
                        state <= NOTIFY;
                    end
                end

                NOTIFY: begin
                    // SYS is raised for the following RELEASE cycle only.
                    sys_q <= notify_latched;
                    state <= RELEASE;
                end

                RELEASE: begin
                    // ID still shows the stale serializing instruction; ignore it.
                    ser_count_q    <= ser_count_q + CNT_W'(1);
                    notify_latched <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Fetch hold request: hazard-driven in IDLE, forced through DRAIN/NOTIFY,
    // and deliberately dropped in RELEASE so fetch moves past the instruction.
    always_comb begin
        want_freeze = 1'b0;
        case (state)
            IDLE:    want_freeze = bus.Fwd_Freeze_IN |
                                   (bus.Valid_IN & bus.Serialize_IN & ~bus.Flush_IN);
            DRAIN:   want_freeze = 1'b1;
            NOTIFY:  want_freeze = 1'b1;
            RELEASE: want_freeze = 1'b0;
            default: want_freeze = 1'b0;
        endcase
    end

    assign bus.Payload_OUT         = payload_q;
    assign bus.Valid_OUT           = valid_q;
    assign bus.Serialize_OUT       = serialize_q;
    assign bus.SYS                 = sys_q;
    assign bus.Serialize_Count_OUT = ser_count_q;
    assign bus.WANT_FREEZE         = want_freeze;
    assign bus.Busy                = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_id_serialize_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_serialize_ctl
//  Brief    : Self-checking bench for id_serialize_ctl: vector table, directed
//             corner sequences and random traffic against a cycle-age model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_serialize_ctl;

    localparam int PW = 32;
    localparam int D  = 3;
    localparam int CW = 2;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    id_serialize_ctl_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

    id_serialize_ctl #(
        .PAYLOAD_W    (PW),
        .DRAIN_CYCLES (D),
        .CNT_W        (CW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "age" = cycles elapsed since a serializing issue
    // (0 = not serializing). Ages 1..D drain, D+1 notify, D+2 release.
    int          m_age;
    bit          m_latch;
    bit          m_valid;
    bit          m_ser;
    bit          m_sys;
    logic [PW-1:0] m_pay;
    int          m_cnt;

    function automatic void model_reset();
        m_age = 0; m_latch = 0; m_valid = 0; m_ser = 0; m_sys = 0; m_pay = '0; m_cnt = 0;
    endfunction

    // One clock cycle: drive at negedge, compare shortly after, advance model.
    task automatic cycle(input bit v, input bit s, input bit n, input bit fwd,
                         input bit fl, input logic [PW-1:0] p);
        bit exp_wf;
        @(negedge CLK);
        bus.Valid_IN = v; bus.Serialize_IN = s; bus.Notify_IN = n;
        bus.Fwd_Freeze_IN = fwd; bus.Flush_IN = fl; bus.Payload_IN = p;
        #1;
        exp_wf = (m_age == 0) ? (fwd | (v & s & ~fl)) : (m_age <= D + 1);
        check("want_freeze", bus.WANT_FREEZE, exp_wf);
        check("busy",        bus.Busy, m_age != 0);
        check("valid_out",   bus.Valid_OUT, m_valid);
        check("payload_out", bus.Payload_OUT, m_pay);
        check("serialize_out", bus.Serialize_OUT, m_ser);
        check("sys",         bus.SYS, m_sys);
        check("count",       bus.Serialize_Count_OUT, m_cnt);
        // Effect of the upcoming edge
        m_valid = 0; m_ser = 0; m_pay = '0; m_sys = 0;
        if (m_age == 0) begin
            if (!fl && !fwd && v) begin
                m_pay = p; m_valid = 1;
                if (s) begin m_ser = 1; m_latch = n; m_age = 1; end
            end
        end else if (m_age == D + 2) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_age = 0;
        end else begin
            m_age++;
            m_sys = (m_age == D + 2) && m_latch;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b1;
    endtask

    typedef struct {
        bit v, s, n, fwd, fl;
        logic [PW-1:0] p;
        bit e_vo;
        logic [PW-1:0] e_po;
        bit e_so, e_wf, e_sys, e_busy;
        int e_cnt;
    } vec_t;

    vec_t tbl[11];
    int   sys_seen;

    initial begin
        bus.Valid_IN = 0; bus.Serialize_IN = 0; bus.Notify_IN = 0;
        bus.Fwd_Freeze_IN = 0; bus.Flush_IN = 0; bus.Payload_IN = '0;

        // Plain stream 1..4, then a syscall (fwd/flush noise during DRAIN).
        //           v s n f l  p   vo po so wf sys busy cnt
        tbl[0]  = '{1,0,0,0,0, 1,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,0,0,0,0, 2,  1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1,0,0,0,0, 3,  1, 2, 0, 0, 0, 0, 0};
        tbl[3]  = '{1,0,0,0,0, 4,  1, 3, 0, 0, 0, 0, 0};
        tbl[4]  = '{1,1,1,0,0, 5,  1, 4, 0, 1, 0, 0, 0};
        tbl[5]  = '{1,1,1,0,0, 5,  1, 5, 1, 1, 0, 1, 0};
        tbl[6]  = '{1,1,1,1,1, 5,  0, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{1,1,1,1,0, 5,  0, 0, 0, 1, 0, 1, 0};
        tbl[8]  = '{1,1,1,0,0, 5,  0, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{1,1,1,0,0, 5,  0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{0,0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 1};

        // Reset state, checked while reset is held
        RESET = 1'b0;
        model_reset();
        #3;
        check("rst_valid", bus.Valid_OUT, 0);
        check("rst_payload", bus.Payload_OUT, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_count", bus.Serialize_Count_OUT, 0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].n, tbl[i].fwd, tbl[i].fl, tbl[i].p);
            check($sformatf("tbl%0d_valid", i), bus.Valid_OUT, tbl[i].e_vo);
            check($sformatf("tbl%0d_payload", i), bus.Payload_OUT, tbl[i].e_po);
            check($sformatf("tbl%0d_ser", i), bus.Serialize_OUT, tbl[i].e_so);
            check($sformatf("tbl%0d_wf", i), bus.WANT_FREEZE, tbl[i].e_wf);
            check($sformatf("tbl%0d_sys", i), bus.SYS, tbl[i].e_sys);
            check($sformatf("tbl%0d_busy", i), bus.Busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_cnt", i), bus.Serialize_Count_OUT, tbl[i].e_cnt);
        end

        // Forwarding freeze holds off a syscall, then LL/SC with no notify.
        cycle(1, 1, 0, 1, 0, 32'h77);
        check("fwd_hold_wf", bus.WANT_FREEZE, 1);
        sys_seen = 0;
        for (int k = 0; k < D + 3; k++) begin
            cycle(1, 1, 0, 0, 0, 32'h88);
            if (k == 0) check("llsc_not_busy_first", bus.Busy, 0);
            if (bus.SYS) sys_seen++;
        end
        cycle(0, 0, 0, 0, 0, 0);
        check("llsc_sys_never", sys_seen, 0);
        check("llsc_count", bus.Serialize_Count_OUT, 2);

        // Reset asserted during NOTIFY abandons the sequence.
        cycle(1, 1, 1, 0, 0, 32'h99);
        for (int k = 0; k < D; k++) cycle(1, 1, 1, 0, 0, 32'h99);
        cycle(1, 1, 1, 0, 0, 32'h99);
        check("in_notify_busy", bus.Busy, 1);
        RESET = 1'b0;
        #1;
        check("rst_mid_busy", bus.Busy, 0);
        check("rst_mid_sys", bus.SYS, 0);
        check("rst_mid_valid", bus.Valid_OUT, 0);
        check("rst_mid_count", bus.Serialize_Count_OUT, 0);
        model_reset();
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0);
        check("post_rst_count", bus.Serialize_Count_OUT, 0);

        // Three serializations to preset the counter to 3.
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < D + 3; k++) cycle(1, 1, 0, 0, 0, 32'h10 + j);
            cycle(0, 0, 0, 0, 0, 0);
        end
        check("preset_count", bus.Serialize_Count_OUT, 3);

        // Back-to-back syscalls: second accepted at T+6, counter wraps 3->0.
        for (int k = 0; k < 2 * (D + 3); k++) begin
            cycle(1, 1, 1, 0, 0, 32'h100 + k);
            if (k == D + 3) begin
                check("b2b_idle_at_t6", bus.Busy, 0);
                check("b2b_wrap_count", bus.Serialize_Count_OUT, 0);
                check("b2b_accept_wf", bus.WANT_FREEZE, 1);
            end
            if (k == D + 4) check("b2b_second_issue", bus.Serialize_OUT, 1);
        end
        cycle(0, 0, 0, 0, 0, 0);
        check("b2b_final_count", bus.Serialize_Count_OUT, 1);

        // Random traffic against the model, with one reset part way through.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) == 0, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
